// File: rtl/ref_sched.sv
// ref_sched: multi-rank SDRAM refresh scheduler.
//
// Keeps one interval timer and one postponed-refresh (debt) counter per rank and presents
// at most one refresh request at a time to the command sequencer. Ranks whose debt has
// reached URGENT_LVL win arbitration first; ties are broken round-robin starting after the
// most recently acknowledged rank.
//
// Ports:
//   clk0          in   clock, all state changes on the rising edge
//   reset_n       in   asynchronous active-low reset
//   refresh_count in   timer reload value, refresh period is refresh_count+1 run cycles
//   bur_len       in   controller configured when nonzero; timers freeze while zero
//   rank_en       in   per-rank enable; a disabled rank has its timer reloaded, debt cleared
//   ref_ack       in   one-cycle pulse completing the currently granted refresh
//   ref_req       out  refresh request
//   ref_rank      out  granted rank, stable while ref_req=1
//   ref_urgent    out  granted rank's debt is at or above URGENT_LVL
//   debt_overflow out  sticky: a tick arrived while a rank's debt was already DEBT_MAX
module ref_sched #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned RANKS      = 2,
  parameter int unsigned RANK_W     = 1,
  parameter int unsigned DEBT_W     = 4,
  parameter int unsigned DEBT_MAX   = 8,
  parameter int unsigned URGENT_LVL = 6,
  parameter int unsigned BURST_SIZE = 3
) (
  input  logic                  clk0,
  input  logic                  reset_n,
  input  logic [CNT_W-1:0]      refresh_count,
  input  logic [BURST_SIZE-1:0] bur_len,
  input  logic [RANKS-1:0]      rank_en,
  input  logic                  ref_ack,
  output logic                  ref_req,
  output logic [RANK_W-1:0]     ref_rank,
  output logic                  ref_urgent,
  output logic                  debt_overflow
);

  localparam logic [DEBT_W-1:0] DebtMax  = DEBT_W'(DEBT_MAX);
  localparam logic [DEBT_W-1:0] UrgLvl   = DEBT_W'(URGENT_LVL);
  localparam logic [RANK_W-1:0] LastRank = RANK_W'(RANKS - 1);

  typedef enum logic {StIdle, StReq} state_e;

  state_e                  state_q, state_d;
  logic [RANK_W-1:0]       rank_q, rank_d;
  logic [RANK_W-1:0]       last_q, last_d;
  logic                    urgent_q, urgent_d;
  logic                    overflow_q, overflow_d;
  logic [CNT_W-1:0]        timer_q [RANKS];
  logic [CNT_W-1:0]        timer_d [RANKS];
  logic [DEBT_W-1:0]       debt_q  [RANKS];
  logic [DEBT_W-1:0]       debt_d  [RANKS];

  logic                    run;
  logic [RANKS-1:0]        tick;
  logic [RANKS-1:0]        dec;
  logic [RANKS-1:0]        pending;
  logic [RANKS-1:0]        urgent_vec;
  logic                    urg_found;
  logic                    any_found;
  logic [RANK_W-1:0]       urg_win;
  logic [RANK_W-1:0]       any_win;

  assign run = (bur_len != '0);

  // Per-rank timers and debt counters.
  always_comb begin
    overflow_d = overflow_q;
    for (int i = 0; i < int'(RANKS); i++) begin
      tick[i]    = run & rank_en[i] & (timer_q[i] == '0);
      dec[i]     = ref_ack & ref_req & (rank_q == RANK_W'(i));
      timer_d[i] = timer_q[i];
      debt_d[i]  = debt_q[i];
      if (!rank_en[i]) begin
        timer_d[i] = refresh_count;
        debt_d[i]  = '0;
      end else begin
        if (tick[i]) begin
          timer_d[i] = refresh_count;
        end else if (run) begin
          // Cannot wrap: a zero timer reloads via tick instead of decrementing.
          timer_d[i] = timer_q[i] - CNT_W'(1);
        end
        // A tick and an ack landing on the same rank cancel out.
        if (tick[i] && !dec[i]) begin
          if (debt_q[i] == DebtMax) begin
            overflow_d = 1'b1;
          end else begin
            debt_d[i] = debt_q[i] + DEBT_W'(1);
          end
        end else if (!tick[i] && dec[i] && (debt_q[i] != '0)) begin
          debt_d[i] = debt_q[i] - DEBT_W'(1);
        end
      end
    end
  end

  // Arbitration: scan offsets from far to near so the nearest candidate after last_q wins.
  always_comb begin
    urg_found = 1'b0;
    any_found = 1'b0;
    urg_win   = '0;
    any_win   = '0;
    for (int i = 0; i < int'(RANKS); i++) begin
      pending[i]    = rank_en[i] & (debt_q[i] != '0);
      urgent_vec[i] = rank_en[i] & (debt_q[i] >= UrgLvl);
    end
    for (int off = int'(RANKS); off > 0; off--) begin
      int idx;
      idx = (int'(last_q) + off) % int'(RANKS);
      if (urgent_vec[idx]) begin
        urg_found = 1'b1;
        urg_win   = RANK_W'(idx);
      end
      if (pending[idx]) begin
        any_found = 1'b1;
        any_win   = RANK_W'(idx);
      end
    end
  end

  // Request FSM.
  always_comb begin
    state_d = state_q;
    rank_d  = rank_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (any_found) begin
          state_d = StReq;
          rank_d  = urg_found ? urg_win : any_win;
        end
      end
      StReq: begin
        if (ref_ack) begin
          state_d = StIdle;
          last_d  = rank_q;
        end else if (!rank_en[rank_q]) begin
          // Grant withdrawn; the disable clears that rank's debt, last_q is untouched.
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Looks at next-state debt so the flag always matches the registered debt of ref_rank.
    urgent_d = (state_d == StReq) && (debt_d[rank_d] >= UrgLvl);
  end

  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      rank_q     <= '0;
      last_q     <= LastRank;
      urgent_q   <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < int'(RANKS); i++) begin
        timer_q[i] <= '0;
        debt_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      rank_q     <= rank_d;
      last_q     <= last_d;
      urgent_q   <= urgent_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < int'(RANKS); i++) begin
        timer_q[i] <= timer_d[i];
        debt_q[i]  <= debt_d[i];
      end
    end
  end

  assign ref_req       = (state_q == StReq);
  assign ref_rank      = rank_q;
  assign ref_urgent    = urgent_q;
  assign debt_overflow = overflow_q;

endmodule

// File: doc/ref_sched.md
# ref_sched

Multi-rank SDRAM refresh scheduler, the parametrised successor of the single-channel refresh timer. It sits in the SDRAM controller between the configuration registers and the command sequencer. It keeps one interval timer per rank and a postponement (debt) counter per rank, and raises one refresh request at a time. Arbitration is urgent-first, then round-robin.

## Interface
- CNT_W, 16, interval timer width
- RANKS, 2, number of ranks
- RANK_W, 1, rank index width, equal to clog2(RANKS)
- DEBT_W, 4, debt counter width
- DEBT_MAX, 8, maximum number of postponed refreshes per rank
- URGENT_LVL, 6, debt level at or above which a rank is urgent
- BURST_SIZE, 3, bur_len width
- clk0  in  1  clock; all state changes on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- refresh_count  in  CNT_W  reload value; the refresh period is refresh_count+1 run cycles
- bur_len  in  BURST_SIZE  controller is configured when nonzero; all timers freeze while it is zero
- rank_en  in  RANKS  per-rank enable
- ref_ack  in  1  one-cycle pulse from the sequencer; completes the currently granted refresh
- ref_req  out  1  refresh request
- ref_rank  out  RANK_W  granted rank; stable while ref_req=1
- ref_urgent  out  1  granted rank's debt is at or above URGENT_LVL
- debt_overflow  out  1  sticky error flag

## Operation
- run = (bur_len != 0).
- tick[i] = run & rank_en[i] & (timer[i]==0). This is combinational.
- Timer i update each cycle:
  - If tick[i]: timer[i] <= refresh_count.
  - Else if run & rank_en[i]: timer[i] <= timer[i]-1.
  - Else if !rank_en[i]: timer[i] <= refresh_count and debt[i] <= 0.
  - Else (!run): hold.
- Debt i: next = debt[i] + tick[i] - dec[i], where dec[i] = ref_ack & ref_req & (ref_rank==i).
  - Tick and dec in the same cycle: debt is unchanged.
  - Tick while debt[i]==DEBT_MAX and no dec: debt holds and debt_overflow <= 1. The flag clears only on reset.
- FSM with two states, IDLE and REQ:
  - IDLE: if any enabled rank has debt>0, pick a winner, then ref_req <= 1, ref_rank <= winner, and go to REQ. ref_ack is ignored in IDLE.
  - Winner selection: the lowest rotation offset after last_grant among urgent ranks. If there are no urgent ranks, the lowest rotation offset after last_grant among ranks with debt>0.
  - REQ, on ref_ack: ref_req <= 0, last_grant <= ref_rank, go to IDLE.
  - REQ, if rank_en[ref_rank] falls: ref_req <= 0, go to IDLE. last_grant and debt are not decremented (debt is cleared by the disable).
- ref_urgent is registered: debt[ref_rank] >= URGENT_LVL while in REQ, otherwise 0.
- Arithmetic:
  - Timer decrement never wraps, because a zero timer reloads.
  - Debt saturates at 0 and DEBT_MAX.
  - refresh_count=0 gives a tick every run cycle.

## Timing
- Reset values: timer=0, debt=0, state IDLE, ref_req=0, ref_rank=0, ref_urgent=0, debt_overflow=0, last_grant=RANKS-1 (so rank 0 wins the first tie).
- First run cycle after reset: timer is 0, so the rank ticks at edge 0 and debt becomes 1. ref_req=1 after edge 1.
- Latency from tick to ref_req is 2 edges when the FSM is IDLE.
- ref_ack at edge k: ref_req=0 after edge k, and debt is decremented at the same edge.
- The next request rises no earlier than edge k+1, so ref_req is low for at least one cycle between grants.
- ref_rank changes only on the IDLE->REQ edge.
- reset_n low clears everything immediately, independent of clk0, including mid-REQ. The first edge after release behaves as the first edge after reset.

## Test plan
- Single rank: reset, refresh_count=4, bur_len=3'b010, rank_en=2'b01. Required: ref_req=1 and ref_rank=0 after edge 1; ack every request; ticks recur every 5 cycles.
- Saturation: rank 0, no acks. Required: ref_urgent=1 once debt reaches 6; debt holds at 8; the 9th unacked tick sets debt_overflow=1, which stays 1 until reset_n=0.
- Round-robin: both ranks enabled with refresh_count=3, ack 2 cycles after each ref_req. Required: ref_rank sequence 0,1,0,1; ref_req low for at least 1 cycle between grants.
- Urgent priority: debt0=2, debt1=6, last_grant=1. Required: next grant ref_rank=1 with ref_urgent=1.
- Simultaneous events: ack coincides with a tick on the granted rank. Required: debt unchanged. With bur_len=0 for 10 cycles: timers and debt hold. Dropping rank_en[ref_rank] in REQ: ref_req=0 next edge and that rank's debt=0.
- Reset mid-REQ: reset_n=0 between clock edges. Required: ref_req, ref_urgent and debt_overflow are 0 before the next edge.
